pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller for the 6-stage core: PC, IF, ID, EX, MEM, WB.
//  Merges stall requests from ID, EX and MEM into the stall[5:0] vector that the PC register and the stage latches consume.
//  Sequences multi-cycle EX operations (mul/div) with an internal down-counter.
//  On an exception or ERET, flushes the pipe and supplies the redirect PC.
// PARAMETERS
//  FLUSH_CYCLES  1             cycles flush stays high per redirect (>=1)
//  MC_CNT_W      6             width of the multi-cycle length/counter
//  EXC_BASE      32'hBFC00380  exception entry address
// PORTS
//  clk            in   1         clock, all state updates on posedge
//  resetn         in   1         synchronous reset, ACTIVE-HIGH despite the name
//  stallreq_id    in   1         ID hazard (load-use)
//  stallreq_ex    in   1         EX single-cycle hold request
//  stallreq_mem   in   1         MEM wait (data memory not ready)
//  mc_start       in   1         pulse: EX begins a multi-cycle op
//  mc_cycles      in   MC_CNT_W  op length N; 0 is treated as 1
//  excp_valid     in   1         exception/ERET committed in MEM
//  eret_i         in   1         qualifies excp_valid as ERET
//  epc_i          in   32        return address for ERET
//  stall          out  6         bit0=PC ... bit5=WB; 1 = hold stage
//  flush          out  1         clear IF..MEM latches
//  new_pc         out  32        redirect target, valid while flush=1
//  mc_busy        out  1         MC_WAIT state active
//  mc_done        out  1         one-cycle pulse on the last multi-cycle cycle
// BEHAVIOUR
//  Reset: state=RUN, cnt=0, flush=0, new_pc=0, mc_done=0; stall=0, mc_busy=0.
//  States
//   RUN: stall is combinational from the requests, using the deepest request:
//     mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; none -> 0.
//   MC_WAIT: stall >= 6'b001111; stallreq_mem raises it to 6'b011111.
//   FLUSH: stall=0; flush=1; new_pc is held; requests, excp and mc_start are ignored.
//  Transitions (evaluated at posedge; priority top-down)
//   excp_valid in RUN or MC_WAIT -> FLUSH.
//     new_pc <= eret_i ? epc_i : EXC_BASE; flush <= 1.
//     Any MC op is aborted with no mc_done. Stall is 0 in the excp cycle.
//   mc_start in RUN -> MC_WAIT with cnt <= max(N,1).
//     Stall is 6'b001111 already in the mc_start cycle (zero latency).
//   MC_WAIT: cnt decrements each cycle.
//     When cnt==1: mc_done=1 (combinational) and stall is still asserted; next state is RUN.
//     Total stalled cycles = N+1 (start cycle + N).
//   FLUSH lasts exactly FLUSH_CYCLES cycles, then RUN; flush drops to 0 that edge.
//  Latency: stall has 0 cycles latency; flush/new_pc are registered (excp at edge t -> flush high from t+1).
//  mc_start while in MC_WAIT or FLUSH is ignored.
//  stallreq_* during FLUSH are ignored (flush wins).
//  Reset mid-MC_WAIT or mid-FLUSH -> RUN immediately; outputs go to reset values the next cycle.
//  The stall vector is always of form 0..01..1 (thermometer); no other codes are produced.
// TESTING
//  T1 Reset held 2 cycles then released, all requests 0 -> stall=0, flush=0, new_pc=0, mc_busy=0.
//  T2 Single-request cycles:
//     stallreq_id=1 -> stall=6'b000111; stallreq_ex=1 -> 6'b001111;
//     id+mem together -> 6'b011111; releasing them -> 0 in the same cycle.
//  T3 mc_start, mc_cycles=4 -> stall=6'b001111 for 5 cycles; mc_done high only on the 5th; then RUN.
//     Repeat with mc_cycles=0 -> 2 stalled cycles.
//  T4 excp_valid=1, eret_i=0 in RUN, FLUSH_CYCLES=1 ->
//     next cycle flush=1, new_pc=32'hBFC00380, stall=0; the following cycle flush=0.
//     Repeat with eret_i=1, epc_i=32'h8000_0040 -> new_pc=32'h8000_0040.
//  T5 mc_cycles=8, excp_valid on the 3rd MC cycle -> FLUSH next cycle, mc_done never pulses, mc_busy=0.
//     A second mc_start during FLUSH is ignored.
//  T6 Reset asserted mid-MC_WAIT (cnt=3) and, separately, mid-FLUSH -> next cycle all outputs 0, state RUN.
//     stallreq_mem during MC_WAIT gives stall=6'b011111.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 6-stage core: merges stall requests into a
// thermometer stall vector, sequences multi-cycle EX ops and redirects on exceptions.
module pipe_ctrl #(
    parameter int          FLUSH_CYCLES = 1,
    parameter int          MC_CNT_W     = 6,
    parameter logic [31:0] EXC_BASE     = 32'hBFC00380
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                excp_valid,
    input  logic                eret_i,
    input  logic [31:0]         epc_i,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                mc_busy,
    output logic                mc_done
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

    state_t              state_reg;
    logic [MC_CNT_W-1:0] cnt_reg;
    logic [FC_W-1:0]     fcnt_reg;
    logic                flush_reg;
    logic [31:0]         new_pc_reg;

    logic [2:0]          depth_next;
    logic                mc_done_next;
    logic                take_excp;

    assign take_excp = excp_valid && (state_reg != FLUSH);

    // Stall depth = number of low stages held (3 = PC..ID, 4 = ..EX, 5 = ..MEM).
    always_comb begin
        depth_next   = 3'd0;
        mc_done_next = 1'b0;
        if (!resetn && !take_excp) begin
            case (state_reg)
                RUN: begin
                    if (stallreq_mem)
                        depth_next = 3'd5;
                    else if (stallreq_ex || mc_start)
                        depth_next = 3'd4;
                    else if (stallreq_id)
                        depth_next = 3'd3;
                end
                MC_WAIT: begin
                    depth_next   = stallreq_mem ? 3'd5 : 3'd4;
                    mc_done_next = (cnt_reg == MC_CNT_W'(1));
                end
                default: depth_next = 3'd0;
            endcase
        end
    end

    // Expanding a depth keeps the vector a thermometer code by construction.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_stall
            assign stall[gi] = (depth_next > 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg  <= RUN;
            cnt_reg    <= '0;
            fcnt_reg   <= '0;
            flush_reg  <= 1'b0;
            new_pc_reg <= 32'd0;
        end else if (take_excp) begin
            state_reg  <= FLUSH;
            cnt_reg    <= '0;
            fcnt_reg   <= FC_W'(FLUSH_CYCLES - 1);
            flush_reg  <= 1'b1;
            new_pc_reg <= eret_i ? epc_i : EXC_BASE;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mc_start) begin
                        state_reg <= MC_WAIT;
                        cnt_reg   <= (mc_cycles == '0) ? MC_CNT_W'(1) : mc_cycles;
                    end
                end
                MC_WAIT: begin
                    cnt_reg <= cnt_reg - MC_CNT_W'(1);
                    if (cnt_reg == MC_CNT_W'(1))
                        state_reg <= RUN;
                end
                FLUSH: begin
                    if (fcnt_reg == '0) begin
                        state_reg <= RUN;
                        flush_reg <= 1'b0;
                    end else begin
                        fcnt_reg <= fcnt_reg - FC_W'(1);
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign flush   = flush_reg;
    assign new_pc  = new_pc_reg;
    assign mc_busy = (state_reg == MC_WAIT);
    assign mc_done = mc_done_next;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, stall merging, multi-cycle sequencing,
// exception/ERET redirect, aborts and reset mid-operation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        excp_valid, eret_i;
    logic [31:0] epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy, mc_done;

    int checks = 0;
    int errors = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .excp_valid   (excp_valid),
        .eret_i       (eret_i),
        .epc_i        (epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance past the next active edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        mc_start = 0; mc_cycles = '0; excp_valid = 0; eret_i = 0; epc_i = '0;

        // T1 reset
        cyc(); cyc();
        resetn = 1'b0; #1;
        check("t1_stall", 32'(stall), 32'h0);
        check("t1_flush", 32'(flush), 32'h0);
        check("t1_new_pc", new_pc, 32'h0);
        check("t1_mc_busy", 32'(mc_busy), 32'h0);
        check("t1_mc_done", 32'(mc_done), 32'h0);

        // T2 single requests, same-cycle response
        stallreq_id = 1; #1;
        check("t2_id", 32'(stall), 32'h07);
        cyc(); stallreq_id = 0; stallreq_ex = 1; #1;
        check("t2_ex", 32'(stall), 32'h0F);
        cyc(); stallreq_ex = 0; stallreq_id = 1; stallreq_mem = 1; #1;
        check("t2_id_mem", 32'(stall), 32'h1F);
        stallreq_id = 0; stallreq_mem = 0; #1;
        check("t2_release", 32'(stall), 32'h0);

        // T3 multi-cycle op, N=4 -> 5 stalled cycles, done on the 5th
        cyc(); mc_start = 1; mc_cycles = 6'd4; #1;
        check("t3_start_stall", 32'(stall), 32'h0F);
        check("t3_start_done", 32'(mc_done), 32'h0);
        cyc(); mc_start = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("t3_mc%0d_stall", i), 32'(stall), 32'h0F);
            check($sformatf("t3_mc%0d_busy", i), 32'(mc_busy), 32'h1);
            check($sformatf("t3_mc%0d_done", i), 32'(mc_done), (i == 4) ? 32'h1 : 32'h0);
            cyc();
        end
        #1;
        check("t3_after_stall", 32'(stall), 32'h0);
        check("t3_after_busy", 32'(mc_busy), 32'h0);

        // T3 N=0 behaves as N=1 -> 2 stalled cycles
        mc_start = 1; mc_cycles = 6'd0; #1;
        check("t3z_start_stall", 32'(stall), 32'h0F);
        cyc(); mc_start = 0; #1;
        check("t3z_mc_stall", 32'(stall), 32'h0F);
        check("t3z_mc_done", 32'(mc_done), 32'h1);
        cyc(); #1;
        check("t3z_after_stall", 32'(stall), 32'h0);
        check("t3z_after_busy", 32'(mc_busy), 32'h0);

        // T4 exception in RUN; a pending request is suppressed in the excp cycle
        excp_valid = 1; eret_i = 0; stallreq_ex = 1; #1;
        check("t4_excp_stall", 32'(stall), 32'h0);
        check("t4_excp_flush", 32'(flush), 32'h0);
        cyc(); excp_valid = 0; stallreq_ex = 0; stallreq_mem = 1; #1;
        check("t4_flush", 32'(flush), 32'h1);
        check("t4_new_pc", new_pc, 32'hBFC00380);
        check("t4_flush_stall", 32'(stall), 32'h0);
        cyc(); stallreq_mem = 0; #1;
        check("t4_flush_drop", 32'(flush), 32'h0);

        // T4 ERET redirects to EPC
        excp_valid = 1; eret_i = 1; epc_i = 32'h8000_0040;
        cyc(); excp_valid = 0; eret_i = 0; epc_i = 32'h0; #1;
        check("t4e_flush", 32'(flush), 32'h1);
        check("t4e_new_pc", new_pc, 32'h8000_0040);
        cyc(); #1;
        check("t4e_flush_drop", 32'(flush), 32'h0);

        // T5 exception aborts an N=8 op on its 3rd MC_WAIT cycle
        mc_start = 1; mc_cycles = 6'd8;
        cyc(); mc_start = 0;
        cyc(); cyc();
        excp_valid = 1; #1;
        check("t5_excp_busy", 32'(mc_busy), 32'h1);
        check("t5_excp_stall", 32'(stall), 32'h0);
        check("t5_excp_done", 32'(mc_done), 32'h0);
        cyc(); excp_valid = 0; mc_start = 1; mc_cycles = 6'd2; #1;
        check("t5_flush", 32'(flush), 32'h1);
        check("t5_flush_busy", 32'(mc_busy), 32'h0);
        check("t5_flush_done", 32'(mc_done), 32'h0);
        check("t5_flush_stall", 32'(stall), 32'h0);
        cyc(); mc_start = 0; #1;
        check("t5_ignored_busy", 32'(mc_busy), 32'h0);
        check("t5_ignored_stall", 32'(stall), 32'h0);
        check("t5_flush_drop", 32'(flush), 32'h0);

        // T6 reset mid-MC_WAIT at cnt=3, with a MEM wait raising the stall
        mc_start = 1; mc_cycles = 6'd5;
        cyc(); mc_start = 0;
        cyc(); cyc();
        stallreq_mem = 1; #1;
        check("t6_mc_mem_stall", 32'(stall), 32'h1F);
        resetn = 1'b1; #1;
        check("t6_rst_stall", 32'(stall), 32'h0);
        cyc(); resetn = 1'b0; stallreq_mem = 0; #1;
        check("t6_mc_busy", 32'(mc_busy), 32'h0);
        check("t6_mc_stall", 32'(stall), 32'h0);
        check("t6_mc_done", 32'(mc_done), 32'h0);

        // T6 reset mid-FLUSH clears the held redirect target
        excp_valid = 1; eret_i = 1; epc_i = 32'h1234_5678;
        cyc(); excp_valid = 0; eret_i = 0; #1;
        check("t6_fl_flush", 32'(flush), 32'h1);
        resetn = 1'b1;
        cyc(); resetn = 1'b0; #1;
        check("t6_fl_flush_rst", 32'(flush), 32'h0);
        check("t6_fl_new_pc", new_pc, 32'h0);
        check("t6_fl_stall", 32'(stall), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
